ibex_dummy_instr_burst: RTL
===========================

// Module: ibex_dummy_instr_burst
// PURPOSE
//  Parametrised dummy-instruction generator for the IF stage (side-channel hardening).
//  Counts real fetched instructions; at an LFSR-chosen threshold it injects a burst of 1..2^BurstW
//  register-to-register dummy ops (rd=x0) ahead of the ID stage.
//  Each class of dummy op can be enabled or disabled on its own. Sits beside the prefetch/fetch FIFO; IF muxes dummy_instr_data_o in.
// PARAMETERS
//  LfsrWidth   32            LFSR width; must be >= CntW+BurstW+12
//  LfsrPoly    32'h80200003  Galois right-shift tap mask
//  DefaultSeed 32'hac533bf4  reset / zero-recovery LFSR state (must be non-zero)
//  CntW        5             inter-burst counter width (>=3)
//  BurstW      2             burst-length field width (max burst 2^BurstW)
// PORTS
//  clk_i               in  1          clock
//  rst_ni              in  1          reset, asynchronous, active-low
//  dummy_instr_en_i    in  1          feature enable
//  dummy_instr_mask_i  in  CntW-2     threshold mask (upper threshold bits)
//  dummy_burst_max_i   in  BurstW     burst-length mask
//  dummy_class_en_i    in  4          per-class enable {AND,DIV,MUL,ADD}; ADD always allowed
//  dummy_seed_en_i     in  1          reseed strobe
//  dummy_seed_i        in  LfsrWidth  reseed entropy
//  fetch_valid_i       in  1          real instruction presented to ID
//  id_in_ready_i       in  1          ID accepts this cycle
//  insert_dummy_instr_o out 1         dummy is valid this cycle (IF selects dummy)
//  dummy_instr_data_o  out 32         dummy instruction word
//  dummy_count_o       out 32         dummies accepted (perf; see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=COUNT, cnt_q=0, seed_q=0, lfsr_q=DefaultSeed, remain_q=0, insert_dummy_instr_o=0, dummy_count_o=0.
//  Seed: on dummy_seed_en_i, seed_q<=seed_q^dummy_seed_i; lfsr_q<=that value (or DefaultSeed if 0). Reseed beats step.
//  LFSR step: lfsr_q<=(lfsr_q>>1)^(lfsr_q[0]?LfsrPoly:0); occurs only when insert_dummy_instr_o & id_in_ready_i.
//  Fields (B=CntW, R2=B+BurstW, R1=R2+5, C=R1+5): thr=lfsr[B-1:0]&{mask,2'b11};
//   blen=lfsr[R2-1:B]&burst_max; rs2=lfsr[R2+4:R2]; rs1=lfsr[R1+4:R1]; cls=lfsr[C+1:C].
//  Class map: 0 ADD f7=0 f3=000 | 1 MUL f7=1 f3=000 | 2 DIV f7=1 f3=100 | 3 AND f7=0 f3=111.
//   If dummy_class_en_i[cls]==0, emit ADD. Word = {f7,rs2,rs1,f3,5'h00,7'h33}, combinational from lfsr_q.
//   Valid in every state.
//  FSM COUNT: insert_o=0. If en & id_in_ready & fetch_valid: cnt_q<=cnt_q+1 (wraps at 2^CntW).
//   If en & cnt_q==thr: ->BURST next cycle; remain_q<=blen+1 (width BurstW+1).
//   Threshold match takes priority over the increment.
//  FSM BURST: insert_o=en. On acceptance (insert_o & id_in_ready_i): remain_q--, LFSR steps.
//   When remain_q==1 and the dummy is accepted: ->COUNT, cnt_q<=0.
//   A stalled ID (id_in_ready_i=0) holds insert_o, word, remain_q.
//  en dropped mid-burst: insert_o=0 same cycle; next cycle ->COUNT, cnt_q<=0, remain_q<=0.
//   While en=0, cnt_q holds.
//  Reseed mid-burst: the burst continues with its captured remain_q; the word reflects the new LFSR.
//  Reset mid-burst: all state returns to reset values asynchronously.
// CONFIGURATION
//  IBEX_DUMMY_INSTR_PERF_EN defined: dummy_count_o increments by 1 per accepted dummy.
//   It saturates at 32'hFFFFFFFF and is cleared only by reset.
//  Undefined: the counter register is not built; dummy_count_o is tied to 32'h0.
// TESTING
//  Reset, en=1, mask=0, burst_max=0, class_en=4'hF -> thr=lfsr[1:0]=0, so cnt_q=0 matches in COUNT;
//   BURST entered; insert_o=1 on 2nd clk after reset release; one dummy, then COUNT with cnt_q=0.
//  burst_max=2'b11, lfsr forced via seed so blen=3 -> exactly 4 consecutive accepted dummies.
//   Each dummy causes one LFSR step; then insert_o=0.
//  id_in_ready_i=0 for 5 cycles during BURST -> insert_o and dummy_instr_data_o stable; remain_q unchanged.
//  class_en=4'b0001, all four cls values -> every word has f7=0, f3=000, opcode 7'h33, rd=0.
//  en deasserted during 2nd of 4 dummies -> insert_o=0 same cycle; COUNT with cnt_q=0 next cycle.
//  PERF_EN: 10 accepted dummies -> dummy_count_o==10. Without macro -> dummy_count_o==0.
//   Reseed with seed_i==0 from seed_q=0 -> lfsr_q==DefaultSeed.

Source files
------------

// File: rtl/ibex_dummy_instr_burst.sv
// ibex_dummy_instr_burst: injects LFSR-timed bursts of rd=x0 register-register dummy ops ahead of ID.
// Ports: clk_i/rst_ni (async active-low); dummy_instr_en_i, dummy_instr_mask_i, dummy_burst_max_i,
//   dummy_class_en_i, dummy_seed_en_i/dummy_seed_i configure; fetch_valid_i/id_in_ready_i track real
//   fetches and acceptance; insert_dummy_instr_o/dummy_instr_data_o present the dummy; dummy_count_o
//   counts accepted dummies only when IBEX_DUMMY_INSTR_PERF_EN is defined (else tied to zero).
module ibex_dummy_instr_burst #(
  parameter int unsigned            LfsrWidth   = 32,
  parameter logic [LfsrWidth-1:0]   LfsrPoly    = 32'h80200003,
  parameter logic [LfsrWidth-1:0]   DefaultSeed = 32'hac533bf4,
  parameter int unsigned            CntW        = 5,
  parameter int unsigned            BurstW      = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 dummy_instr_en_i,
  input  logic [CntW-3:0]      dummy_instr_mask_i,
  input  logic [BurstW-1:0]    dummy_burst_max_i,
  input  logic [3:0]           dummy_class_en_i,
  input  logic                 dummy_seed_en_i,
  input  logic [LfsrWidth-1:0] dummy_seed_i,
  input  logic                 fetch_valid_i,
  input  logic                 id_in_ready_i,
  output logic                 insert_dummy_instr_o,
  output logic [31:0]          dummy_instr_data_o,
  output logic [31:0]          dummy_count_o
);
  localparam int unsigned B  = CntW;
  localparam int unsigned R2 = B + BurstW;
  localparam int unsigned R1 = R2 + 5;
  localparam int unsigned C  = R1 + 5;
  typedef enum logic {COUNT, BURST} state_e;
  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d, thr;
  logic [LfsrWidth-1:0] seed_q, seed_d, lfsr_q, lfsr_d, lfsr_step;
  logic [BurstW:0]      remain_q, remain_d;
  logic [BurstW-1:0]    blen;
  logic [1:0]           cls, cls_eff;
  logic [6:0]           f7;
  logic [2:0]           f3;
  logic                 accept;
  always_comb begin
    thr                  = lfsr_q[B-1:0] & {dummy_instr_mask_i, 2'b11};
    blen                 = lfsr_q[R2-1:B] & dummy_burst_max_i;
    cls                  = lfsr_q[C+1:C];
    cls_eff              = dummy_class_en_i[cls] ? cls : 2'd0;
    f7                   = (cls_eff == 2'd1 || cls_eff == 2'd2) ? 7'h01 : 7'h00;
    f3                   = cls_eff == 2'd2 ? 3'b100 : cls_eff == 2'd3 ? 3'b111 : 3'b000;
    dummy_instr_data_o   = {f7, lfsr_q[R2+4:R2], lfsr_q[R1+4:R1], f3, 5'h00, 7'h33};
    insert_dummy_instr_o = (state_q == BURST) && dummy_instr_en_i;
    accept               = insert_dummy_instr_o && id_in_ready_i;
    lfsr_step            = (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrPoly : '0);
    seed_d               = dummy_seed_en_i ? seed_q ^ dummy_seed_i : seed_q;
    // A reseed overrides the step; an all-zero LFSR would lock up, so fall back to DefaultSeed.
    lfsr_d               = dummy_seed_en_i ? (seed_d == '0 ? DefaultSeed : seed_d) :
                           accept ? lfsr_step : lfsr_q;
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    remain_d = remain_q;
    if (state_q == COUNT) begin
      if (dummy_instr_en_i && cnt_q == thr) begin
        state_d  = BURST;
        remain_d = {1'b0, blen} + (BurstW+1)'(1);
      end else if (dummy_instr_en_i && id_in_ready_i && fetch_valid_i) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (!dummy_instr_en_i) begin
      state_d  = COUNT;
      cnt_d    = '0;
      remain_d = '0;
    end else if (accept) begin
      remain_d = remain_q - (BurstW+1)'(1);
      if (remain_q == (BurstW+1)'(1)) begin
        state_d = COUNT;
        cnt_d   = '0;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= COUNT;
      cnt_q    <= '0;
      seed_q   <= '0;
      lfsr_q   <= DefaultSeed;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      seed_q   <= seed_d;
      lfsr_q   <= lfsr_d;
      remain_q <= remain_d;
    end
  end
`ifdef IBEX_DUMMY_INSTR_PERF_EN
  logic [31:0] count_q, count_d;
  always_comb count_d = (accept && count_q != '1) ? count_q + 32'd1 : count_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end
  assign dummy_count_o = count_q;
`else
  assign dummy_count_o = 32'h0;
`endif
endmodule
